// File: rtl/register_file_if.sv
// Register file access bus: two read ports and one write port.
//   left_read_*  : left operand read port (enable, register number, data)
//   right_read_* : right operand read port (enable, register number, data)
//   write_*      : writeback port (strobe, register number, data)
// master drives enables/numbers/write data; slave returns read data.
interface register_file_if #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 5
);
  logic                  left_read_enable;
  logic [SEL_WIDTH-1:0]  left_read_number;
  logic [WORD_WIDTH-1:0] left_read_bus;
  logic                  right_read_enable;
  logic [SEL_WIDTH-1:0]  right_read_number;
  logic [WORD_WIDTH-1:0] right_read_bus;
  logic                  write_enable;
  logic [SEL_WIDTH-1:0]  write_number;
  logic [WORD_WIDTH-1:0] write_bus;

  modport master (
    output left_read_enable, left_read_number,
    output right_read_enable, right_read_number,
    output write_enable, write_number, write_bus,
    input  left_read_bus, right_read_bus
  );

  modport slave (
    input  left_read_enable, left_read_number,
    input  right_read_enable, right_read_number,
    input  write_enable, write_number, write_bus,
    output left_read_bus, right_read_bus
  );
endinterface

// File: rtl/register_file.sv
// General-purpose register file: two combinational read ports with
// write-through bypass and one synchronous write port.
//   clock : rising-edge write clock
//   reset : asynchronous active-low clear of all registers; forces reads to 0
//   bus   : register_file_if slave (read ports + write port)
module register_file #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input logic            clock,
  input logic            reset,
  register_file_if.slave bus
);

  logic [WORD_WIDTH-1:0] regs [NUM_REGS];

  logic write_valid_c;
  logic left_valid_c;
  logic right_valid_c;

  // Register numbers beyond the implemented range are treated as absent.
  assign write_valid_c = 32'(bus.write_number)      < NUM_REGS;
  assign left_valid_c  = 32'(bus.left_read_number)  < NUM_REGS;
  assign right_valid_c = 32'(bus.right_read_number) < NUM_REGS;

  // Storage: one register updated per edge; clear wins over any write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (bus.write_enable && write_valid_c) begin
      regs[bus.write_number] <= bus.write_bus;
    end
  end

  // Left read port; a same-cycle write to the same register is forwarded.
  always_comb begin
    bus.left_read_bus = '0;
    if (reset && bus.left_read_enable && left_valid_c) begin
      if (bus.write_enable && (bus.left_read_number == bus.write_number)) begin
        bus.left_read_bus = bus.write_bus;
      end else begin
        bus.left_read_bus = regs[bus.left_read_number];
      end
    end
  end

  // Right read port; same forwarding rule, independent of the left port.
  always_comb begin
    bus.right_read_bus = '0;
    if (reset && bus.right_read_enable && right_valid_c) begin
      if (bus.write_enable && (bus.right_read_number == bus.write_number)) begin
        bus.right_read_bus = bus.write_bus;
      end else begin
        bus.right_read_bus = regs[bus.right_read_number];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: stimulus pushes expected read-bus
// values into a queue; a monitor samples both buses and compares.
module tb_register_file;

  localparam int unsigned WW = 32;
  localparam int unsigned SW = 5;
  localparam int unsigned NR = 32;

  typedef struct {
    string         name;
    logic [WW-1:0] left;
    logic [WW-1:0] right;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  event sample_ev;

  register_file_if #(.WORD_WIDTH(WW), .SEL_WIDTH(SW)) rf ();

  register_file #(.WORD_WIDTH(WW), .SEL_WIDTH(SW), .NUM_REGS(NR)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (rf.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Queue an expectation; the monitor samples 1 time unit after the event.
  task automatic expect_buses(input string name, input logic [WW-1:0] l,
                              input logic [WW-1:0] r);
    exp_t e;
    #1;
    e.name  = name;
    e.left  = l;
    e.right = r;
    exp_q.push_back(e);
    -> sample_ev;
    #2;
  endtask

  task automatic set_reads(input logic le, input int li, input logic re, input int ri);
    rf.left_read_enable  = le;
    rf.left_read_number  = SW'(li);
    rf.right_read_enable = re;
    rf.right_read_number = SW'(ri);
  endtask

  task automatic set_write(input logic we, input int wn, input logic [WW-1:0] wd);
    rf.write_enable = we;
    rf.write_number = SW'(wn);
    rf.write_bus    = wd;
  endtask

  // Monitor: pops one expectation per sample and compares both buses.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: sample with empty queue");
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (rf.left_read_bus !== e.left) begin
          errors++;
          $display("FAIL %s left: got %h expected %h", e.name, rf.left_read_bus, e.left);
        end
        checks++;
        if (rf.right_read_bus !== e.right) begin
          errors++;
          $display("FAIL %s right: got %h expected %h", e.name, rf.right_read_bus, e.right);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;

    // Reset with an active all-ones write: buses held at 0, write ignored.
    reset = 1'b0;
    set_write(1'b1, 0, 32'hFFFF_FFFF);
    set_reads(1'b1, 0, 1'b1, 0);
    expect_buses("reset_bus", 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    set_write(1'b0, 0, 32'hFFFF_FFFF);

    // Every register is zero after release.
    for (int i = 0; i < int'(NR); i++) begin
      @(negedge clock);
      set_reads(1'b1, i, 1'b1, int'(NR) - 1 - i);
      expect_buses("post_reset", 32'h0, 32'h0);
    end

    // Sequential fill: register i <= i.
    for (int i = 0; i < int'(NR); i++) begin
      @(negedge clock);
      set_write(1'b1, i, WW'(i));
      set_reads(1'b0, 0, 1'b0, 0);
      @(posedge clock);
    end
    @(negedge clock);
    set_write(1'b0, 0, 32'h0);

    // Readback on left, reverse order on right.
    for (int i = 0; i < int'(NR); i++) begin
      @(negedge clock);
      set_reads(1'b1, i, 1'b1, int'(NR) - 1 - i);
      expect_buses("fill_read", WW'(i), WW'(int'(NR) - 1 - i));
    end

    // Dual reads.
    @(negedge clock); set_reads(1'b1, 3, 1'b1, 17);
    expect_buses("dual_3_17", 32'd3, 32'd17);
    @(negedge clock); set_reads(1'b1, 9, 1'b1, 9);
    expect_buses("dual_9_9", 32'd9, 32'd9);

    // Read disable, then enable in the same cycle.
    @(negedge clock); set_reads(1'b0, 5, 1'b1, 5);
    expect_buses("disable_left", 32'd0, 32'd5);
    rf.left_read_enable = 1'b1;
    rf.right_read_enable = 1'b0;
    expect_buses("enable_left", 32'd5, 32'd0);

    // Bypass on both ports before the edge; unrelated read unaffected.
    @(negedge clock);
    set_write(1'b1, 7, 32'hDEAD_BEEF);
    set_reads(1'b1, 7, 1'b1, 8);
    expect_buses("bypass_left", 32'hDEAD_BEEF, 32'd8);
    @(negedge clock);
    set_reads(1'b0, 7, 1'b1, 7);
    expect_buses("bypass_right", 32'd0, 32'hDEAD_BEEF);
    @(negedge clock);
    set_write(1'b0, 7, 32'h0);
    set_reads(1'b1, 7, 1'b1, 6);
    expect_buses("after_write", 32'hDEAD_BEEF, 32'd6);

    // Disabled write leaves register 2 unchanged.
    @(negedge clock);
    set_write(1'b0, 2, 32'h1234_5678);
    set_reads(1'b1, 2, 1'b1, 5);
    @(posedge clock);
    @(negedge clock);
    expect_buses("write_disabled", 32'd2, 32'd5);

    // Asynchronous reset between edges, with a pending write.
    @(negedge clock);
    set_write(1'b1, 2, 32'hAAAA_5555);
    #1;
    reset = 1'b0;
    expect_buses("async_reset", 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    set_write(1'b0, 0, 32'h0);
    expect_buses("after_reset", 32'h0, 32'h0);

    // First write right after release lands on the next edge.
    @(negedge clock);
    set_write(1'b1, 4, 32'h0000_00A4);
    @(posedge clock);
    @(negedge clock);
    set_write(1'b0, 0, 32'h0);
    set_reads(1'b1, 4, 1'b1, 9);
    expect_buses("first_write", 32'h0000_00A4, 32'h0);

    #10;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
